// File: rtl/mdu_pkg.sv
// +---------------------------------------------------------------------------+
// | mdu_pkg : op encodings and FSM state type for mult_div_unit               |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_abs_neg.sv
// +---------------------------------------------------------------------------+
// | mdu_abs_neg : conditional two's-complement negate (out = neg ? -in : in)  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? (~in_val + {{(WIDTH-1){1'b0}}, 1'b1}) : in_val;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// +---------------------------------------------------------------------------+
// | mult_div_unit : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.          |
// | Optional macro MDU_EARLY_TERM_EN: multiply exits once multiplier is 0.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      cnt;
    logic               neg_main;
    logic               neg_rem;
    logic               dz;
`ifdef MDU_EARLY_TERM_EN
    logic [WIDTH-1:0]   mrem;
`endif

    logic               is_div;
    logic               is_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] fix_acc;
    logic [2*WIDTH-1:0] fix_res;
    logic [WIDTH-1:0]   rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign sa        = is_signed & a_q[WIDTH-1];
    assign sb        = is_signed & b_q[WIDTH-1];
    assign busy      = (state != S_IDLE);

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.in_val(a_q), .neg(sa), .out_val(a_abs));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.in_val(b_q), .neg(sb), .out_val(b_abs));

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd});
    // When div_ok the difference is below opnd, so the modulo-2^W subtract is exact.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

`ifdef MDU_EARLY_TERM_EN
    // An early exit leaves cnt un-run shifts; apply them in one step.
    assign fix_acc = {acc_hi, acc_lo} >> cnt;
`else
    assign fix_acc = {acc_hi, acc_lo};
`endif

    // Negating the 2W value also yields the negated quotient in its low half.
    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_main (.in_val(fix_acc), .neg(neg_main), .out_val(fix_res));
    mdu_abs_neg #(.WIDTH(WIDTH))   u_fix_rem  (.in_val(acc_hi),  .neg(neg_rem),  .out_val(rem_fix));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                if (is_div && (b_q == '0)) begin
                    state_nxt = S_FIX;
`ifdef MDU_EARLY_TERM_EN
                end else if (!is_div && (b_q == '0)) begin
                    state_nxt = S_FIX;
`endif
                end else begin
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (cnt == CW'(1)) begin
                    state_nxt = S_FIX;
`ifdef MDU_EARLY_TERM_EN
                end else if (!is_div && (mrem[WIDTH-1:1] == '0)) begin
                    state_nxt = S_FIX;
`endif
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MDU_EARLY_TERM_EN
            mrem     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                S_PREP: begin
                    cnt      <= CW'(WIDTH);
                    dz       <= is_div && (b_q == '0);
                    neg_main <= sa ^ sb;
                    neg_rem  <= is_div & sa;
                    acc_hi   <= '0;
                    if (is_div) begin
                        opnd   <= b_abs;
                        acc_lo <= a_abs;
                    end else begin
                        opnd   <= a_abs;
                        acc_lo <= b_abs;
                    end
`ifdef MDU_EARLY_TERM_EN
                    mrem     <= b_abs;
`endif
                end
                S_ITER: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
`ifdef MDU_EARLY_TERM_EN
                    mrem <= mrem >> 1;
`endif
                end
                S_FIX: begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (!dz) begin
                        lo <= fix_res[WIDTH-1:0];
                        hi <= is_div ? rem_fix : fix_res[2*WIDTH-1:WIDTH];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +---------------------------------------------------------------------------+
// | tb_mult_div_unit : vector table, corner sequences and random ops vs model |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: arithmetic on 64-bit integers, latency from the timing rules.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ehi, output logic [W-1:0] elo,
                         output logic edz, output int elat);
        longint      sa, sb, q, r;
        logic [63:0] p, mag;
        int          n;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        edz = 1'b0;
        elat = W + 2;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = 64'(a) * 64'(b);
            2'b10: begin
                if (b == '0) begin edz = 1'b1; p = {mhi, mlo}; end
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == '0) begin edz = 1'b1; p = {mhi, mlo}; end
                else p = {32'(a % b), 32'(a / b)};
            end
        endcase
        if (edz) elat = 2;
`ifdef MDU_EARLY_TERM_EN
        if (op[1] == 1'b0) begin
            mag = (op == 2'b00 && sb < 0) ? 64'(-sb) : 64'(b);
            n = 0;
            while (mag != 0) begin n++; mag = mag >> 1; end
            elat = n + 2;
        end
`endif
        ehi = p[63:32];
        elo = p[31:0];
        mhi = ehi;
        mlo = elo;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ghi, output logic [W-1:0] glo,
                         output logic gdz, output int lat, output logic bsy_ok);
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start  = 1'b0;
        bsy_ok = busy;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
            if (!busy) bsy_ok = 1'b0;
        end
        if (busy) bsy_ok = 1'b0;
        ghi = hi; glo = lo; gdz = div_zero;
    endtask

    vec_t         vecs[9];
    logic [W-1:0] ghi, glo, ehi, elo;
    logic         gdz, edz, bok;
    int           lat, elat, ndone;

    initial begin
        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[5] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[7] = '{2'b01, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0};
        vecs[8] = '{2'b11, 32'd47,       32'd7,        32'd5,        32'd6,        1'b0};

        rst_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, ghi, glo, gdz, lat, bok);
            model(vecs[i].op, vecs[i].a, vecs[i].b, ehi, elo, edz, elat);
            chk($sformatf("vec%0d_hi", i), 64'(ghi), 64'(vecs[i].ehi));
            chk($sformatf("vec%0d_lo", i), 64'(glo), 64'(vecs[i].elo));
            chk($sformatf("vec%0d_dz", i), 64'(gdz), 64'(vecs[i].edz));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(elat));
            chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
        end

        // Divide by zero: hi/lo keep 5/6 from vec8, flag pulses once.
        do_op(2'b11, 32'd100, 32'd0, ghi, glo, gdz, lat, bok);
        model(2'b11, 32'd100, 32'd0, ehi, elo, edz, elat);
        chk("dz_lat", 64'(lat), 64'd2);
        chk("dz_flag", 64'(gdz), 64'd1);
        chk("dz_hilo", {ghi, glo}, {32'd5, 32'd6});
        @(posedge clk); #1;
        chk("dz_pulse", {62'd0, done, div_zero}, 64'd0);

        // Reset during iteration 10 of a MULT.
        @(negedge clk);
        start = 1'b1; op_i = 2'b00; a_i = 32'h1234567; b_i = 32'h89ABCDE;
        @(posedge clk); #1; start = 1'b0;
        repeat (11) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
        chk("mid_rst_nodone", 64'(ndone), 64'd0);
        mhi = '0; mlo = '0;

        // Second start while busy is ignored.
        @(negedge clk);
        start = 1'b1; op_i = 2'b11; a_i = 32'd1000; b_i = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd3;
        @(negedge clk); start = 1'b0;
        ndone = 0; ghi = '0; glo = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) begin ndone++; ghi = hi; glo = lo; end
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_hilo", {ghi, glo}, {32'd6, 32'd142});
        mhi = 32'd6; mlo = 32'd142;

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            int           sel;
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            else if (sel == 2) rb = rb >> $urandom_range(0, 31);
            do_op(rop, ra, rb, ghi, glo, gdz, lat, bok);
            model(rop, ra, rb, ehi, elo, edz, elat);
            chk($sformatf("rnd%0d_hilo", i), {ghi, glo}, {ehi, elo});
            chk($sformatf("rnd%0d_dz", i), 64'(gdz), 64'(edz));
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit that produces the HI/LO register pair for the multicycle datapath.
- Supports MULT, MULTU, DIV and DIVU, one result bit per cycle, with a start/busy/done handshake to the control FSM.
- Owns the HI and LO registers internally. The datapath reads hi/lo directly for MFHI/MFLO.
- Generalises the fixed 32-bit HI/LO path to WIDTH bits and adds a divide-by-zero flag.

Parameters:
WIDTH, 32, operand and result width; hi and lo are each WIDTH bits (WIDTH >= 4).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  operation request; sampled only in IDLE
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
busy  output  1  high from the first edge after start is accepted until done
done  output  1  one-cycle pulse; hi/lo are final in the same cycle
div_zero  output  1  one-cycle pulse together with done when a DIV or DIVU has b == 0
hi  output  WIDTH  MULT: upper product; DIV: remainder
lo  output  WIDTH  MULT: lower product; DIV: quotient

Behaviour:
- Reset (reset=0, async): state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal accumulators and counter cleared.
- FSM states: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op, a, b; go to PREP.
  - busy rises after E0.
  - start while busy is ignored; no queueing.
- PREP (E1):
  - Signed ops convert a and b to magnitudes and record the result signs: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Counter loads WIDTH.
  - DIV/DIVU with b==0: go to FIX with a div_zero flag; hi/lo keep their previous values.
- ITER (W edges, E2..E(W+1)):
  - MUL: shift-add. Add the multiplicand to the upper 2W-accumulator half when the multiplier LSB is 1, then shift right.
  - DIV: restoring. Shift the remainder left with the next dividend MSB, subtract the divisor if there is no borrow, and shift the quotient bit in.
  - Counter decrements each edge; at 0 go to FIX.
- FIX (E(W+2)):
  - Apply two's-complement sign correction to the product, quotient and remainder.
  - Write hi/lo; done=1 (and div_zero=1 for the zero-divisor case) for exactly the following cycle.
  - busy=0 from the same edge; return to IDLE.
  - start may be accepted in the cycle done is high.
- Latency:
  - Normal operation: done is high W+2 edges after E0 (34 for WIDTH=32).
  - Divide by zero: done is high 2 edges after E0.
- Arithmetic rules:
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - MIN/-1 gives lo=MIN, hi=0 with no flag.
  - MULTU/DIVU treat operands as unsigned.
- Reset mid-operation aborts immediately to the reset values; no done pulse.
- Inputs a, b, op may change while busy without effect.

Optional Feature:
MDU_EARLY_TERM_EN
- Defined: in MUL, ITER exits to FIX once the remaining shifted multiplier is 0, checked before each iteration.
  - Latency is n+2 edges, where n = number of significant bits of |b|.
  - b=0 gives 2 edges. DIV timing is unchanged.
- Undefined: fixed W+2 latency for all multiplies.

Decomposition:
- Package mdu_pkg:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - state enum (S_IDLE, S_PREP, S_ITER, S_FIX)
- Sub-module mdu_abs_neg (WIDTH): combinational conditional two's-complement negate. Reused for operand magnitude in PREP and sign correction in FIX.

Test Plan:
- MULT a=FFFFFFFD (-3), b=7 -> done 34 edges after start; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles before done.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 with hi/lo preloaded 5/6 -> done and div_zero pulse 2 edges after start; hi=5, lo=6 unchanged.
- Reset asserted at iteration 10 of a MULT -> busy=0, hi=lo=0 immediately, no done. Second start pulsed while busy -> ignored; exactly one done.
- MDU_EARLY_TERM_EN defined: MULTU a=5, b=3 -> done 4 edges after start, lo=15, hi=0. Macro undefined -> same result at 34 edges.
